spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
SPI slave endpoint that answers the Wishbone SPI master core on the far side of the SPI link. Inputs: ss/sclk/mosi pads. Output: miso pad.
- Synchronises all pad inputs into the system clock domain and detects sclk edges.
- Shifts one character per frame slot, using the same char_len/lsb/edge-select semantics as the master core.
- Exposes a one-entry tx holding buffer (valid/ready) and an rx data register with a strobe to local logic.

Parameters:
SPI_MAX_CHAR, 32, maximum character length in bits; also the tx_data_i/rx_data_o width.
CHAR_LEN_BITS, 5, width of char_len_i; equals log2(SPI_MAX_CHAR).

Ports:
wb_clk_i  in  1  system clock; the only clock.
wb_rst_n_i  in  1  asynchronous active-low reset.
ss_pad_i  in  1  slave select, active low, asynchronous to wb_clk_i.
sclk_pad_i  in  1  serial clock from master, asynchronous.
mosi_pad_i  in  1  master out slave in, asynchronous.
miso_pad_o  out  1  master in slave out data.
miso_oe_o  out  1  miso output enable; 1 only while the synchronised ss is low.
char_len_i  in  CHAR_LEN_BITS  character length; 0 means SPI_MAX_CHAR.
lsb_i  in  1  1 = LSB first on the line, 0 = MSB first.
rx_negedge_i  in  1  1 = sample mosi on the sclk falling edge, 0 = on the rising edge.
tx_negedge_i  in  1  1 = advance miso on the sclk falling edge, 0 = on the rising edge.
tx_data_i  in  SPI_MAX_CHAR  next character to transmit.
tx_valid_i  in  1  tx_data_i is valid.
tx_ready_o  out  1  tx holding buffer is empty.
rx_data_o  out  SPI_MAX_CHAR  last received character, right-aligned; upper bits are 0.
rx_valid_o  out  1  one-cycle strobe: rx_data_o has been updated.
underrun_o  out  1  one-cycle strobe: a character started with the tx buffer empty.
frame_err_o  out  1  one-cycle strobe: ss deasserted mid-character.

Behaviour:
- Reset values:
  - miso_pad_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0.
  - rx_valid_o=0, underrun_o=0, frame_err_o=0.
  - All synchronisers reset to the idle level: ss=1, sclk=0, mosi=0.
  - Bit counter = 0, shift register = 0.
- Synchronisers: 2-flop synchroniser on each of ss, sclk and mosi, plus one delay stage on sclk for edge detection.
  - An internal rise/fall pulse occurs 3 cycles after the pad edge.
  - Supported when f_sclk <= f_wb_clk/8.
- Config inputs char_len_i, lsb_i, rx_negedge_i and tx_negedge_i are sampled at each character start and held for that character.
- Tx buffer:
  - When tx_ready_o=1 and tx_valid_i=1, capture tx_data_i and drop tx_ready_o on the next cycle.
  - The buffer empties, and tx_ready_o rises, in the cycle the shift register loads from it.
- Character start: the synchronised ss falls, or ss is still low after the previous character completes.
  - Buffer full: shift register <= buffer.
  - Buffer empty: shift register <= 0 and underrun_o pulses.
  - Bit counter <= 0.
  - miso_pad_o presents bit 0 (LSB if lsb_i=1, else bit len-1) on the cycle after the load.
- Sample edge (the edge selected by rx_negedge_i) while ss is low:
  - Shift the synchronised mosi into the rx shifter.
  - Increment the bit counter.
- Drive edge (the edge selected by tx_negedge_i): advance miso to the next bit only if at least one sample edge has occurred in this character.
  - This covers both master phase conventions; the first driving edge before any sample is ignored.
- Completion: the sample edge that makes counter == len.
  - The next cycle, rx_data_o <= the assembled character, right-aligned, with bit order restored per lsb_i.
  - rx_valid_o pulses for 1 cycle.
  - If ss is still low, the next character starts immediately in that same cycle.
- rx_data_o is overwritten on each completion; there is no backpressure and no overrun flag.
- ss rises with counter != 0:
  - frame_err_o pulses, the partial character is discarded, and rx_data_o is unchanged.
  - The counter is cleared and miso_oe_o drops.
  - A character already loaded from the buffer is lost; there is no reload.
- ss rises with counter == 0: return to idle silently.
- Simultaneous tx_valid_i with a character-start load from an empty buffer: the load takes 0 (underrun). The new data is captured into the buffer in the same cycle and is used for the next character.
- Reset mid-frame: all state returns to the reset values immediately.
- FSM states:
  - IDLE: ss high. On ss low -> LOAD.
  - LOAD: 1 cycle. -> SHIFT.
  - SHIFT: on completion with ss low -> LOAD; on ss high -> IDLE.

Decomposition:
- Shared package spi_slave_pkg:
  - FSM state encoding.
  - Synchroniser depth constant (2).
  - Defaults for SPI_MAX_CHAR and CHAR_LEN_BITS, kept consistent with the master's character-length defines.
- One sub-module, spi_slave_sync: the 2-flop synchroniser plus sclk edge detector, outputting ss_s, mosi_s, sclk_rise and sclk_fall.

Test Plan:
- Mode rx_neg=0, tx_neg=1, len=8, MSB first; tx buffer 0xA5; master sends 0x3C -> rx_data_o=0x3C with one rx_valid_o pulse; master captures 0xA5; tx_ready_o rises at LOAD.
- Same transfer with rx_neg=1, tx_neg=0, lsb=1 -> rx_data_o=0x3C; master captures 0xA5; the first driving edge does not advance miso.
- char_len=0, 32-bit transfer of 0xDEADBEEF both ways -> rx_data_o=0xDEADBEEF.
- Two back-to-back 8-bit characters under one ss-low, buffer refilled after the first load -> two rx_valid_o pulses; the second character uses the new buffer data.
- Buffer empty at ss fall -> underrun_o pulse; master reads 0x00; rx still received correctly.
- ss raised after 5 of 8 bits -> frame_err_o pulse, no rx_valid_o, rx_data_o unchanged; next frame works. Reset asserted mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave endpoint: FSM encoding, synchroniser
// depth and the character-length defaults matching the master core.
package spi_slave_pkg;

    localparam int SPI_MAX_CHAR_DEF  = 32;
    localparam int CHAR_LEN_BITS_DEF = 5;
    localparam int SYNC_DEPTH        = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_t;

endpackage

// File: rtl/spi_slave_if.sv
// Local-logic side of the SPI slave: tx holding buffer handshake, rx data
// register and the status strobes.
interface spi_slave_if
    import spi_slave_pkg::*;
#(
    parameter int SPI_MAX_CHAR = SPI_MAX_CHAR_DEF
);
    logic [SPI_MAX_CHAR-1:0] tx_data_i;
    logic                    tx_valid_i;
    logic                    tx_ready_o;
    logic [SPI_MAX_CHAR-1:0] rx_data_o;
    logic                    rx_valid_o;
    logic                    underrun_o;
    logic                    frame_err_o;

    modport slave (
        input  tx_data_i, tx_valid_i,
        output tx_ready_o, rx_data_o, rx_valid_o, underrun_o, frame_err_o
    );

    modport master (
        output tx_data_i, tx_valid_i,
        input  tx_ready_o, rx_data_o, rx_valid_o, underrun_o, frame_err_o
    );
endinterface

// File: rtl/spi_slave_sync.sv
// Brings the asynchronous ss/sclk/mosi pads into wb_clk_i and turns the
// synchronised sclk into single-cycle rise/fall pulses.
module spi_slave_sync
    import spi_slave_pkg::*;
(
    input  logic wb_clk_i,
    input  logic wb_rst_n_i,
    input  logic ss_pad_i,
    input  logic sclk_pad_i,
    input  logic mosi_pad_i,
    output logic ss_s,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall
);
    // Bit order {mosi, sclk, ss}; reset to the idle line levels.
    localparam logic [2:0] IDLE_LVL = 3'b001;

    logic [2:0] pad_in;
    logic [2:0] sync_s;
    logic       sclk_d_reg;

    assign pad_in = {mosi_pad_i, sclk_pad_i, ss_pad_i};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_DEPTH-1:0] chain_reg;

            always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
                if (!wb_rst_n_i) begin
                    chain_reg <= {SYNC_DEPTH{IDLE_LVL[gi]}};
                end else begin
                    chain_reg <= {chain_reg[SYNC_DEPTH-2:0], pad_in[gi]};
                end
            end

            assign sync_s[gi] = chain_reg[SYNC_DEPTH-1];
        end
    endgenerate

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            sclk_d_reg <= 1'b0;
        end else begin
            sclk_d_reg <= sync_s[1];
        end
    end

    assign ss_s      = sync_s[0];
    assign mosi_s    = sync_s[2];
    assign sclk_rise =  sync_s[1] & ~sclk_d_reg;
    assign sclk_fall = ~sync_s[1] &  sclk_d_reg;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint for the Wishbone SPI master: shifts one character per
// slot with master-compatible char_len/lsb/edge semantics.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SPI_MAX_CHAR  = SPI_MAX_CHAR_DEF,
    parameter int CHAR_LEN_BITS = CHAR_LEN_BITS_DEF
)(
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     ss_pad_i,
    input  logic                     sclk_pad_i,
    input  logic                     mosi_pad_i,
    output logic                     miso_pad_o,
    output logic                     miso_oe_o,
    input  logic [CHAR_LEN_BITS-1:0] char_len_i,
    input  logic                     lsb_i,
    input  logic                     rx_negedge_i,
    input  logic                     tx_negedge_i,
    spi_slave_if.slave               bus
);
    localparam int CNT_W = CHAR_LEN_BITS + 1;
    localparam int IDX_W = $clog2(SPI_MAX_CHAR);

    logic ss_s, mosi_s, sclk_rise, sclk_fall;

    spi_slave_sync u_sync (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .ss_pad_i   (ss_pad_i),
        .sclk_pad_i (sclk_pad_i),
        .mosi_pad_i (mosi_pad_i),
        .ss_s       (ss_s),
        .mosi_s     (mosi_s),
        .sclk_rise  (sclk_rise),
        .sclk_fall  (sclk_fall)
    );

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        len_reg, len_next;
    logic                    lsb_reg, lsb_next;
    logic                    rx_neg_reg, rx_neg_next;
    logic                    tx_neg_reg, tx_neg_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [SPI_MAX_CHAR-1:0] tx_buf_reg, tx_buf_next;
    logic                    tx_full_reg, tx_full_next;
    logic [SPI_MAX_CHAR-1:0] tx_shift_reg, tx_shift_next;
    logic [SPI_MAX_CHAR-1:0] rx_shift_reg, rx_shift_next;
    logic [SPI_MAX_CHAR-1:0] rx_data_reg, rx_data_next;
    logic                    rx_valid_reg, rx_valid_next;
    logic                    underrun_reg, underrun_next;
    logic                    frame_err_reg, frame_err_next;

    logic                    sample_edge, drive_edge;
    logic [CNT_W-1:0]        len_cfg, cnt_inc;
    logic [SPI_MAX_CHAR-1:0] rx_shift_in, rx_rev;
    logic [IDX_W-1:0]        msb_idx, src_idx;

    assign sample_edge = rx_neg_reg ? sclk_fall : sclk_rise;
    assign drive_edge  = tx_neg_reg ? sclk_fall : sclk_rise;
    assign len_cfg     = (char_len_i == '0) ? CNT_W'(SPI_MAX_CHAR) : {1'b0, char_len_i};
    assign cnt_inc     = cnt_reg + CNT_W'(1);
    assign rx_shift_in = {rx_shift_reg[SPI_MAX_CHAR-2:0], mosi_s};
    assign msb_idx     = IDX_W'(len_reg - CNT_W'(1));

    // The first bit on the wire lands highest; LSB-first needs it mirrored
    // back within the character width.
    always_comb begin
        rx_rev  = '0;
        src_idx = '0;
        for (int i = 0; i < SPI_MAX_CHAR; i++) begin
            if (i < int'(len_reg)) begin
                src_idx   = IDX_W'(int'(len_reg) - 1 - i);
                rx_rev[i] = rx_shift_in[src_idx];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        lsb_next       = lsb_reg;
        rx_neg_next    = rx_neg_reg;
        tx_neg_next    = tx_neg_reg;
        cnt_next       = cnt_reg;
        tx_buf_next    = tx_buf_reg;
        tx_full_next   = tx_full_reg;
        tx_shift_next  = tx_shift_reg;
        rx_shift_next  = rx_shift_reg;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = 1'b0;
        underrun_next  = 1'b0;
        frame_err_next = 1'b0;

        if (!tx_full_reg && bus.tx_valid_i) begin
            tx_full_next = 1'b1;
            tx_buf_next  = bus.tx_data_i;
        end

        case (state_reg)
            ST_IDLE: begin
                if (!ss_s) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                len_next      = len_cfg;
                lsb_next      = lsb_i;
                rx_neg_next   = rx_negedge_i;
                tx_neg_next   = tx_negedge_i;
                cnt_next      = '0;
                rx_shift_next = '0;
                if (tx_full_reg) begin
                    tx_shift_next = tx_buf_reg;
                    tx_full_next  = 1'b0;
                end else begin
                    tx_shift_next = '0;
                    underrun_next = 1'b1;
                end
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (ss_s) begin
                    frame_err_next = (cnt_reg != '0);
                    cnt_next       = '0;
                    state_next     = ST_IDLE;
                end else begin
                    // A drive edge before the first sample belongs to the
                    // other phase convention and must not consume bit 0.
                    if (drive_edge && cnt_reg != '0) begin
                        tx_shift_next = lsb_reg ? (tx_shift_reg >> 1) : (tx_shift_reg << 1);
                    end
                    if (sample_edge) begin
                        rx_shift_next = rx_shift_in;
                        cnt_next      = cnt_inc;
                        if (cnt_inc == len_reg) begin
                            cnt_next      = '0;
                            rx_data_next  = lsb_reg ? rx_rev : rx_shift_in;
                            rx_valid_next = 1'b1;
                            state_next    = ST_LOAD;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            lsb_reg       <= 1'b0;
            rx_neg_reg    <= 1'b0;
            tx_neg_reg    <= 1'b0;
            cnt_reg       <= '0;
            tx_buf_reg    <= '0;
            tx_full_reg   <= 1'b0;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            underrun_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            lsb_reg       <= lsb_next;
            rx_neg_reg    <= rx_neg_next;
            tx_neg_reg    <= tx_neg_next;
            cnt_reg       <= cnt_next;
            tx_buf_reg    <= tx_buf_next;
            tx_full_reg   <= tx_full_next;
            tx_shift_reg  <= tx_shift_next;
            rx_shift_reg  <= rx_shift_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            underrun_reg  <= underrun_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign miso_pad_o      = lsb_reg ? tx_shift_reg[0] : tx_shift_reg[msb_idx];
    assign miso_oe_o       = ~ss_s;
    assign bus.tx_ready_o  = ~tx_full_reg;
    assign bus.rx_data_o   = rx_data_reg;
    assign bus.rx_valid_o  = rx_valid_reg;
    assign bus.underrun_o  = underrun_reg;
    assign bus.frame_err_o = frame_err_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master on the pads,
// a table of single-character frames and hand-written corner sequences.
module tb_spi_slave;
    import spi_slave_pkg::*;

    localparam int W    = 32;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic       miso, miso_oe;
    logic [4:0] char_len = 5'd8;
    logic       lsb = 1'b0, rx_neg = 1'b0, tx_neg = 1'b1;

    spi_slave_if #(.SPI_MAX_CHAR(W)) bus ();

    spi_slave #(.SPI_MAX_CHAR(W), .CHAR_LEN_BITS(5)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n_i   (rst_n),
        .ss_pad_i     (ss),
        .sclk_pad_i   (sclk),
        .mosi_pad_i   (mosi),
        .miso_pad_o   (miso),
        .miso_oe_o    (miso_oe),
        .char_len_i   (char_len),
        .lsb_i        (lsb),
        .rx_negedge_i (rx_neg),
        .tx_negedge_i (tx_neg),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rx_neg;
        logic        tx_neg;
        logic        lsb;
        logic [4:0]  len;
        logic [31:0] tx;
        logic [31:0] mo;
    } vec_t;

    vec_t        vecs[5];
    int          checks = 0, errors = 0;
    int          rx_cnt = 0, ur_cnt = 0, fe_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rx = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every rx_valid_o pulse pops the oldest expected word.
    task automatic run_monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.rx_valid_o) begin
                    rx_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: got 0x%0h, expected no rx_valid", bus.rx_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", bus.rx_data_o, e);
                        $display("rx  data=0x%08h", bus.rx_data_o);
                    end
                end
                if (bus.underrun_o)  ur_cnt++;
                if (bus.frame_err_o) fe_cnt++;
            end
        end
    endtask

    task automatic half_wait();
        repeat (HALF) @(negedge clk);
    endtask

    // cpha=0: drive mosi before the rising edge, sample miso on it.
    // cpha=1: drive on the rising edge, sample miso on the falling edge.
    task automatic spi_char(input logic [31:0] mo, input int n, input bit lsbf,
                            input bit cpha, output logic [31:0] mi);
        int b;
        mi = '0;
        for (int i = 0; i < n; i++) begin
            b = lsbf ? i : n - 1 - i;
            if (!cpha) begin
                mosi = mo[b];
                half_wait();
                sclk = 1'b1;
                mi[b] = miso;
                half_wait();
                sclk = 1'b0;
            end else begin
                sclk = 1'b1;
                mosi = mo[b];
                half_wait();
                sclk = 1'b0;
                mi[b] = miso;
                half_wait();
            end
        end
    endtask

    task automatic push_tx(input logic [31:0] d);
        int t;
        t = 0;
        while (!bus.tx_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.tx_ready_o) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: tx_ready_o stayed 0, required 1");
        end
        bus.tx_data_i  = d;
        bus.tx_valid_i = 1'b1;
        @(negedge clk);
        bus.tx_valid_i = 1'b0;
        check("tx_ready_after_push", {31'b0, bus.tx_ready_o}, 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_miso",      {31'b0, miso},            32'd0);
        check("rst_miso_oe",   {31'b0, miso_oe},         32'd0);
        check("rst_tx_ready",  {31'b0, bus.tx_ready_o},  32'd1);
        check("rst_rx_data",   bus.rx_data_o,            32'd0);
        check("rst_rx_valid",  {31'b0, bus.rx_valid_o},  32'd0);
        check("rst_underrun",  {31'b0, bus.underrun_o},  32'd0);
        check("rst_frame_err", {31'b0, bus.frame_err_o}, 32'd0);
    endtask

    function automatic logic [31:0] len_mask(input int n);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF;
        return ones >> (32 - n);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          nb, t, r0, u0, f0;
        logic [31:0] mi, mi2, m;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 5'd8,  32'h0000_00A5, 32'h0000_003C};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 5'd8,  32'h0000_00A5, 32'h0000_003C};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 5'd5,  32'h0000_0015, 32'h0000_000A};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 5'd16, 32'h0000_1234, 32'h0000_BEEF};

        bus.tx_data_i  = '0;
        bus.tx_valid_i = 1'b0;
        fork
            run_monitor();
        join_none

        repeat (4) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        foreach (vecs[k]) begin
            char_len = vecs[k].len;
            lsb      = vecs[k].lsb;
            rx_neg   = vecs[k].rx_neg;
            tx_neg   = vecs[k].tx_neg;
            nb       = (vecs[k].len == 0) ? 32 : int'(vecs[k].len);
            m        = len_mask(nb);
            push_tx(vecs[k].tx);
            r0 = rx_cnt; u0 = ur_cnt; f0 = fe_cnt;
            exp_q.push_back(vecs[k].mo & m);
            last_rx = vecs[k].mo & m;
            ss = 1'b0;
            t = 0;
            while (!bus.tx_ready_o && t < HALF) begin
                @(negedge clk);
                t++;
            end
            check("tx_ready_at_load", {31'b0, bus.tx_ready_o}, 32'd1);
            half_wait();
            spi_char(vecs[k].mo, nb, vecs[k].lsb, vecs[k].rx_neg, mi);
            half_wait();
            ss = 1'b1;
            repeat (2 * HALF) @(negedge clk);
            check("master_rx", mi, vecs[k].tx & m);
            check("rx_pulses", rx_cnt - r0, 32'd1);
            // The reload after the last character finds the buffer empty.
            check("underrun_pulses", ur_cnt - u0, 32'd1);
            check("frame_err_pulses", fe_cnt - f0, 32'd0);
            check("scoreboard_drained", exp_q.size(), 32'd0);
            $display("vec %0d len=%0d lsb=%0d rxneg=%0d master_got=0x%08h", k, nb,
                     vecs[k].lsb, vecs[k].rx_neg, mi);
        end

        // Two characters under one ss-low, buffer refilled after the first load.
        char_len = 5'd8; lsb = 1'b0; rx_neg = 1'b0; tx_neg = 1'b1;
        push_tx(32'h11);
        r0 = rx_cnt; u0 = ur_cnt;
        exp_q.push_back(32'h5A);
        exp_q.push_back(32'hC3);
        ss = 1'b0;
        half_wait();
        push_tx(32'h22);
        spi_char(32'h5A, 8, 1'b0, 1'b0, mi);
        spi_char(32'hC3, 8, 1'b0, 1'b0, mi2);
        half_wait();
        ss = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        last_rx = 32'hC3;
        check("b2b_master_rx0", mi, 32'h11);
        check("b2b_master_rx1", mi2, 32'h22);
        check("b2b_rx_pulses", rx_cnt - r0, 32'd2);
        check("b2b_underrun_pulses", ur_cnt - u0, 32'd1);
        $display("b2b master_got=0x%02h,0x%02h", mi, mi2);

        // Buffer empty at ss fall: zeros go out, rx still works.
        r0 = rx_cnt; u0 = ur_cnt;
        exp_q.push_back(32'h96);
        ss = 1'b0;
        half_wait();
        spi_char(32'h96, 8, 1'b0, 1'b0, mi);
        half_wait();
        ss = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        last_rx = 32'h96;
        check("ur_master_rx", mi, 32'h00);
        check("ur_rx_pulses", rx_cnt - r0, 32'd1);
        check("ur_underrun_pulses", ur_cnt - u0, 32'd2);
        $display("underrun master_got=0x%02h", mi);

        // ss raised after 5 of 8 bits.
        push_tx(32'h77);
        r0 = rx_cnt; f0 = fe_cnt;
        ss = 1'b0;
        half_wait();
        spi_char(32'h1F, 5, 1'b0, 1'b0, mi);
        half_wait();
        ss = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("fe_pulses", fe_cnt - f0, 32'd1);
        check("fe_no_rx", rx_cnt - r0, 32'd0);
        check("fe_rx_hold", bus.rx_data_o, last_rx);
        check("fe_tx_ready", {31'b0, bus.tx_ready_o}, 32'd1);
        $display("frame_err partial master_got=0x%02h", mi);

        push_tx(32'h5C);
        exp_q.push_back(32'h3A);
        ss = 1'b0;
        half_wait();
        spi_char(32'h3A, 8, 1'b0, 1'b0, mi);
        half_wait();
        ss = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        last_rx = 32'h3A;
        check("post_fe_master_rx", mi, 32'h5C);
        check("post_fe_drained", exp_q.size(), 32'd0);
        $display("post frame_err master_got=0x%02h", mi);

        // Reset in the middle of a character.
        push_tx(32'hF0);
        ss = 1'b0;
        half_wait();
        spi_char(32'h07, 3, 1'b0, 1'b0, mi);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        check_reset_outputs();
        ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        $display("reset mid-frame applied");

        lsb = 1'b1; rx_neg = 1'b1; tx_neg = 1'b0;
        push_tx(32'h81);
        exp_q.push_back(32'h7E);
        ss = 1'b0;
        half_wait();
        spi_char(32'h7E, 8, 1'b1, 1'b1, mi);
        half_wait();
        ss = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("post_rst_master_rx", mi, 32'h81);
        check("post_rst_drained", exp_q.size(), 32'd0);
        $display("post reset master_got=0x%02h", mi);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
